// File: rtl/spi_byte_shifter.sv
// SPI mode-0 master byte engine, MSB first, SCLK divided synchronously from clk.
// One byte takes 16*H clk cycles; start is ignored (not queued) while busy.
module spi_byte_shifter (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] speed_select,
   input  logic [7:0] tx_data,
   input  logic       start,
   input  logic       miso,
   output logic       sclk,
   output logic       mosi,
   output logic [7:0] rx_data,
   output logic       busy,
   output logic       done
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t     state_q, state_d;
   logic [6:0] phase_q, phase_d;
   logic [6:0] hm1_q, hm1_d;
   logic [2:0] bit_q, bit_d;
   logic       sclk_q, sclk_d;
   logic       mosi_q, mosi_d;
   logic [7:0] tx_sr_q, tx_sr_d;
   logic [7:0] rx_sr_q, rx_sr_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       done_q, done_d;
   logic [7:0] h_full;
   logic [7:0] h_m1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         phase_q   <= 7'd0;
         hm1_q     <= 7'd0;
         bit_q     <= 3'd0;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b1;
         tx_sr_q   <= 8'h00;
         rx_sr_q   <= 8'h00;
         rx_data_q <= 8'h00;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         hm1_q     <= hm1_d;
         bit_q     <= bit_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         tx_sr_q   <= tx_sr_d;
         rx_sr_q   <= rx_sr_d;
         rx_data_q <= rx_data_d;
         done_q    <= done_d;
      end
   end

   // Half-period is stored as H-1 so that H=128 fits the 7-bit phase counter.
   always_comb begin
      h_full = 8'd1 << speed_select[2:0];
      h_m1   = h_full - 8'd1;
   end

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      hm1_d     = hm1_q;
      bit_d     = bit_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      tx_sr_d   = tx_sr_q;
      rx_sr_d   = rx_sr_q;
      rx_data_d = rx_data_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SHIFT;
               tx_sr_d = tx_data;
               mosi_d  = tx_data[7];
               hm1_d   = speed_select[3] ? h_m1[6:0] : 7'd0;
               phase_d = 7'd0;
               bit_d   = 3'd0;
               sclk_d  = 1'b0;
            end
         end
         SHIFT: begin
            if (phase_q == hm1_q) begin
               phase_d = 7'd0;
               if (!sclk_q) begin
                  sclk_d  = 1'b1;
                  rx_sr_d = {rx_sr_q[6:0], miso};
               end else begin
                  sclk_d = 1'b0;
                  // Eighth falling edge ends the byte; done is the transition itself.
                  if (bit_q == 3'd7) begin
                     state_d   = IDLE;
                     done_d    = 1'b1;
                     rx_data_d = rx_sr_q;
                     mosi_d    = 1'b1;
                  end else begin
                     bit_d   = bit_q + 3'd1;
                     mosi_d  = tx_sr_q[6];
                     tx_sr_d = {tx_sr_q[6:0], 1'b0};
                  end
               end
            end else begin
               phase_d = phase_q + 7'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign sclk    = sclk_q;
   assign mosi    = mosi_q;
   assign rx_data = rx_data_q;
   assign busy    = (state_q == SHIFT);
   assign done    = done_q;

endmodule

// File: tb/tb_spi_byte_shifter.sv
// Directed bench for spi_byte_shifter: expected bytes and completion cycles go
// into a scoreboard queue at start; a monitor process checks them on done.
module tb_spi_byte_shifter;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] speed_select;
   logic [7:0] tx_data;
   logic       start;
   logic       miso;
   logic       sclk;
   logic       mosi;
   logic [7:0] rx_data;
   logic       busy;
   logic       done;

   spi_byte_shifter dut (
      .clk          (clk),
      .reset        (reset),
      .speed_select (speed_select),
      .tx_data      (tx_data),
      .start        (start),
      .miso         (miso),
      .sclk         (sclk),
      .mosi         (mosi),
      .rx_data      (rx_data),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   int cyc;
   always @(posedge clk) cyc <= cyc + 1;

   // Slave model: presents slave_byte MSB first, advancing on each SCLK fall.
   logic       loop_en;
   logic [7:0] slave_byte;
   int         fall_cnt;
   int         slave_base;
   always @(negedge sclk) fall_cnt <= fall_cnt + 1;

   function automatic logic slave_pick(input logic [7:0] b, input int k);
      if (k >= 0 && k < 8) return b[7-k];
      return 1'b1;
   endfunction

   assign miso = loop_en ? mosi : slave_pick(slave_byte, fall_cnt - slave_base);

   logic [7:0] mosi_log;
   always @(posedge sclk) mosi_log <= {mosi_log[6:0], mosi};

   // SCLK high/low run lengths and busy duration, cleared at each accepted start.
   int hi_run, lo_run, hi_min, hi_max, lo_min, lo_max, pulses, busy_cnt;
   always @(negedge clk) begin
      if (start && !busy) begin
         hi_run   <= 0;
         lo_run   <= 0;
         hi_min   <= 1000;
         hi_max   <= 0;
         lo_min   <= 1000;
         lo_max   <= 0;
         pulses   <= 0;
         busy_cnt <= 0;
      end else begin
         if (busy) busy_cnt <= busy_cnt + 1;
         if (sclk) begin
            hi_run <= hi_run + 1;
            if (lo_run != 0) begin
               if (lo_run < lo_min) lo_min <= lo_run;
               if (lo_run > lo_max) lo_max <= lo_run;
               lo_run <= 0;
               pulses <= pulses + 1;
            end
         end else begin
            if (hi_run != 0) begin
               if (hi_run < hi_min) hi_min <= hi_run;
               if (hi_run > hi_max) hi_max <= hi_run;
               hi_run <= 0;
            end
            if (busy) lo_run <= lo_run + 1;
            else      lo_run <= 0;
         end
      end
   end

   typedef struct {
      logic [7:0] rx;
      int         at;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks;
   int   n_fail;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic go(input logic [3:0] ss, input logic [7:0] tx,
                     input logic [7:0] exp_rx, input int h);
      speed_select = ss;
      tx_data      = tx;
      slave_base   = fall_cnt;
      start        = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      sb.push_back(exp_t'{rx: exp_rx, at: cyc + 16 * h});
   endtask

   task automatic wait_done(input int limit);
      int n;
      n = 0;
      while (!done && n < limit) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("done_seen", done, 1);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset        = 1'b1;
      start        = 1'b0;
      loop_en      = 1'b1;
      speed_select = 4'h0;
      tx_data      = 8'h00;
      slave_byte   = 8'h00;

      fork
         forever begin
            @(negedge clk);
            if (done) begin
               check("sb_nonempty", (sb.size() > 0), 1);
               if (sb.size() > 0) begin
                  mon_e = sb.pop_front();
                  check("rx_data", rx_data, mon_e.rx);
                  check("done_cycle", cyc, mon_e.at);
               end
            end
         end
      join_none

      cycles(2);
      check("rst_sclk", sclk, 0);
      check("rst_mosi", mosi, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rx", rx_data, 8'h00);
      reset = 1'b0;
      cycles(2);

      // Fast loopback
      loop_en = 1'b1;
      go(4'h0, 8'hA5, 8'hA5, 1);
      check("t1_busy", busy, 1);
      check("t1_mosi_first", mosi, 1);
      wait_done(40);
      @(negedge clk); #1;
      check("t1_pulses", pulses, 8);
      check("t1_hi_min", hi_min, 1);
      check("t1_hi_max", hi_max, 1);
      check("t1_busy_cnt", busy_cnt, 16);
      cycles(3);

      // Divided rate with slave driving 0x96
      loop_en    = 1'b0;
      slave_byte = 8'h96;
      go(4'hB, 8'h3C, 8'h96, 8);
      wait_done(300);
      @(negedge clk); #1;
      check("t2_hi_min", hi_min, 8);
      check("t2_hi_max", hi_max, 8);
      check("t2_lo_min", lo_min, 8);
      check("t2_lo_max", lo_max, 8);
      check("t2_busy_cnt", busy_cnt, 128);
      check("t2_pulses", pulses, 8);
      check("t2_mosi_bits", mosi_log, 8'h3C);
      check("t2_mosi_idle", mosi, 1);
      cycles(3);

      // Start while busy is ignored
      loop_en = 1'b1;
      go(4'h8, 8'h00, 8'h00, 1);
      cycles(5);
      tx_data = 8'hFF;
      start   = 1'b1;
      cycles(1);
      start = 1'b0;
      wait_done(40);
      @(negedge clk); #1;
      check("t3_mosi_bits", mosi_log, 8'h00);
      check("t3_pulses", pulses, 8);
      cycles(20);
      check("t3_single_done", sb.size(), 0);
      check("t3_idle", busy, 0);

      // Back-to-back: second start presented in the done cycle
      go(4'h0, 8'h81, 8'h81, 1);
      wait_done(40);
      go(4'h0, 8'h5A, 8'h5A, 1);
      check("t4_busy_next", busy, 1);
      wait_done(40);
      @(negedge clk); #1;
      check("t4_rx", rx_data, 8'h5A);
      cycles(3);

      // Reset in the middle of bit 4 at H=128
      go(4'hF, 8'h0F, 8'h0F, 128);
      cycles(7 * 128 + 10);
      check("t5_busy_pre", busy, 1);
      check("t5_sclk_pre", sclk, 1);
      #2;
      reset = 1'b1;
      #1;
      check("t5_sclk", sclk, 0);
      check("t5_mosi", mosi, 1);
      check("t5_busy", busy, 0);
      check("t5_rx", rx_data, 8'h00);
      check("t5_done", done, 0);
      sb.delete();
      cycles(1);
      reset = 1'b0;
      cycles(1);
      check("t5_idle_after", busy, 0);
      cycles(4);
      go(4'h0, 8'hC3, 8'hC3, 1);
      wait_done(40);
      @(negedge clk); #1;
      check("t5_fresh_rx", rx_data, 8'hC3);
      cycles(3);

      // Speed change mid-transfer has no effect
      go(4'h9, 8'h69, 8'h69, 2);
      cycles(10);
      speed_select = 4'h0;
      wait_done(80);
      @(negedge clk); #1;
      check("t6_hi_min", hi_min, 2);
      check("t6_hi_max", hi_max, 2);
      check("t6_lo_min", lo_min, 2);
      check("t6_lo_max", lo_max, 2);
      check("t6_busy_cnt", busy_cnt, 32);

      cycles(5);
      check("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_byte_shifter.md
# spi_byte_shifter

SPI master byte engine that consumes the serial-clock rate selection used elsewhere in the breakout. It generates SCLK as a synchronous divided signal from the Z80 clock rather than a gated clock. It shifts one byte out on MOSI while capturing one byte from MISO, using SPI mode 0, MSB first. It sits between the Z80 I/O register decode and the external SPI pins, and reports completion with a busy/done handshake.

## Interface
Parameters: none.

Ports:
- clk  input  1  Z80 system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high.
- speed_select  input  4  SCLK rate selection; sampled only at transfer start.
- tx_data  input  8  byte to transmit; sampled only at transfer start.
- start  input  1  transfer request; one clk cycle is sufficient.
- miso  input  1  serial data from the slave; assumed stable around SCLK rising edges.
- sclk  output  1  SPI clock; idles low.
- mosi  output  1  serial data to the slave; idles high.
- rx_data  output  8  last received byte; holds its value until the next completion.
- busy  output  1  high while a transfer is in progress.
- done  output  1  single-cycle pulse when rx_data is updated.

## Operation
- Half-period H, in clk cycles:
  - speed_select[3]=0: H=1 (fastest).
  - speed_select[3]=1: H=2^speed_select[2:0], so 1..128.
- H is latched at start. Changes to speed_select mid-transfer have no effect.
- States:
  - IDLE: busy=0, sclk=0, mosi=1.
  - SHIFT: 8 bits, 16 half-periods.
  - IDLE again after the final half-period. There is no separate DONE state; done is asserted on the transition.
- IDLE to SHIFT:
  - Requires start=1 at a clk edge while busy=0.
  - On that edge: tx_data goes to the shift register, H is latched, and the phase and bit counters clear.
  - Outputs after that edge: busy=1, sclk=0, mosi=tx_data[7].
- In SHIFT, a phase counter counts 0..H-1. When it reaches H-1, sclk toggles and the counter wraps to 0.
  - Rising toggle: sample miso into the receive shift register LSB, shifting left.
  - Falling toggle that is not the 8th: mosi takes the next bit (tx[6] down to tx[0]).
  - 8th falling toggle: sclk=0, busy=0, done=1, rx_data takes the 8 captured bits (first captured bit is rx_data[7]), mosi=1. State returns to IDLE.
- start while busy=1 is ignored. It is not queued.
- start asserted in the done cycle (busy=0) is accepted, giving back-to-back transfers with no idle SCLK gap beyond that one cycle.
- Phase counter is 7 bits. Bit counter is 3 bits, plus the sclk level, to detect the 8th fall. No wrap hazards: H≤128 fits exactly.

## Timing
- Reset values: sclk=0, mosi=1, busy=0, done=0, rx_data=8'h00, state IDLE. Reset applies asynchronously.
- Reset during SHIFT:
  - Aborts immediately.
  - rx_data returns to 8'h00 and done is not pulsed.
  - The first clk edge after reset deasserts sees IDLE.
- Edge E0 is the clk edge sampling start=1. Relative to E0:
  - Rising SCLK i (i=1..8) occurs at E0+(2i−1)H.
  - MISO bit i is sampled at that same edge.
  - Falling SCLK i occurs at E0+2iH.
- busy is high after E0 through E0+16H−1 and low after E0+16H.
- done is high only for the cycle following edge E0+16H.
- rx_data is valid from E0+16H and stable until the next completion.
- MOSI setup to a rising SCLK edge is H clk cycles. MOSI changes coincide with falling SCLK edges.
- Total transfer is 16H cycles. At the fastest setting that is 16 cycles, so SCLK = clk/2.

## Test plan
- Fast loopback: speed_select=4'h0, miso tied to mosi, tx_data=8'hA5, start one cycle.
  - Expect rx_data=8'hA5 and done exactly 16 cycles after the start edge.
  - Expect 8 SCLK pulses, each high for 1 cycle.
- Divided rate: speed_select=4'hB (H=8), tx_data=8'h3C, slave model drives 8'h96 MSB-first on falling SCLK edges.
  - Expect rx_data=8'h96.
  - Expect busy high for 128 cycles and SCLK high/low intervals of exactly 8 cycles each.
  - Check the MOSI bitstream equals 0,0,1,1,1,1,0,0.
- Ignore while busy: second start with tx_data=8'hFF mid-transfer of 8'h00 (speed 4'h8).
  - Expect a single transfer, MOSI all zeros, and one done pulse.
- Back-to-back: assert start in the done cycle with tx_data=8'h5A under loopback.
  - Expect the second transfer to begin on the next edge and rx_data=8'h5A after a further 16H cycles.
- Reset mid-transfer: assert reset at bit 4 of a speed 4'hF transfer.
  - Expect sclk=0, mosi=1, busy=0, rx_data=8'h00 immediately, with no done pulse.
  - Then a fresh transfer of 8'hC3 completes correctly.
- Speed change mid-transfer: start at 4'h9, switch speed_select to 4'h0 after 10 cycles.
  - Expect all half-periods to remain 2 cycles for the whole transfer.
